// File: rtl/npu_pipe_ctrl.sv
// Valid/ready sequencer for a chain of external datapath pipeline registers.
// Emits per-stage load enables, collapses bubbles, honours backpressure and flush, and counts tiles.
module npu_pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 8,
    parameter int OCC_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic [OCC_W-1:0]  occupancy,
    output logic              busy,
    output logic              tile_done,
    output logic [CNT_W-1:0]  tile_count
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] l;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] u;
    logic [STAGES-1:0] lin;
    logic              run;
    logic              xfer_last;

    // A stage advances unless it and every stage downstream of it is full and the consumer stalls.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        adv       = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full_tail = full_tail & v[i];
            adv[i]    = out_ready | ~full_tail;
        end
    end

    always_comb begin
        u      = '0;
        lin    = '0;
        u[0]   = in_valid;
        lin[0] = in_last;
        for (int i = 1; i < STAGES; i++) begin
            u[i]   = v[i-1];
            lin[i] = l[i-1];
        end
    end

    assign run       = reset & ~flush;
    assign in_ready  = run & adv[0];
    assign stage_en  = run ? (adv & u) : '0;
    assign out_valid = run & v[STAGES-1];
    assign out_last  = out_valid & l[STAGES-1];
    assign busy      = reset & ((|v) | in_valid);
    assign xfer_last = out_valid & out_ready & l[STAGES-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
        if (!reset) begin
            occupancy = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            l <= '0;
        end else if (flush) begin
            v <= '0;
            l <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (adv[i]) begin
                    v[i] <= u[i];
                    l[i] <= u[i] & lin[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tile_done  <= 1'b0;
            tile_count <= '0;
        end else begin
            tile_done <= xfer_last;
            if (xfer_last) begin
                tile_count <= tile_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_npu_pipe_ctrl.sv
// Scoreboard bench for npu_pipe_ctrl: models external data registers driven by stage_en and
// compares every retired beat and the tile counters against expectations queued at acceptance.
module tb_npu_pipe_ctrl;

    localparam int S = 4;

    logic         clk;
    logic         reset;
    logic         in_valid, in_last, out_ready, flush;
    logic         in_ready, out_valid, out_last, busy, tile_done;
    logic [S-1:0] stage_en;
    logic [4:0]   occupancy;
    logic [7:0]   tile_count;
    logic         in_ready_b, out_valid_b, out_last_b, busy_b, tile_done_b;
    logic [S-1:0] stage_en_b;
    logic [4:0]   occupancy_b;
    logic [1:0]   tile_count_b;
    logic [7:0]   in_data;

    int n_cmp = 0;
    int n_err = 0;

    npu_pipe_ctrl #(.STAGES(S), .CNT_W(8), .OCC_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .flush(flush), .stage_en(stage_en),
        .occupancy(occupancy), .busy(busy), .tile_done(tile_done),
        .tile_count(tile_count)
    );

    npu_pipe_ctrl #(.STAGES(S), .CNT_W(2), .OCC_W(5)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_last(out_last_b),
        .out_ready(out_ready), .flush(flush), .stage_en(stage_en_b),
        .occupancy(occupancy_b), .busy(busy_b), .tile_done(tile_done_b),
        .tile_count(tile_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // external data registers, loaded from enables sampled mid-cycle
    logic [7:0]   d [S];
    logic [S-1:0] en_s;
    logic [7:0]   din_s;
    initial en_s = '0;
    always @(negedge clk) begin
        en_s  = stage_en;
        din_s = in_data;
    end
    always @(posedge clk) begin
        for (int i = 0; i < S; i++) begin
            if (en_s[i]) d[i] <= (i == 0) ? din_s : d[i-1];
        end
    end

    logic [8:0] q[$];
    logic [8:0] e;
    logic       exp_done = 1'b0;
    int         exp_cnt  = 0;
    logic       xl;

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            exp_done = 1'b0;
            exp_cnt  = 0;
        end else begin
            chk("tile_done", tile_done, exp_done);
            chk("tile_count", tile_count, exp_cnt % 256);
            chk("tile_done_w2", tile_done_b, exp_done);
            chk("tile_count_w2", tile_count_b, exp_cnt % 4);
            xl = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", d[S-1], e[7:0]);
                    chk("sb_last", out_last, e[8]);
                    xl = e[8];
                end
            end
            if (in_valid && in_ready) q.push_back({in_last, in_data});
            if (flush) q.delete();
            exp_done = xl;
            if (xl) exp_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen, rises, dones, n;
        logic prev;
        reset = 1'b0; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
        flush = 1'b0; in_data = 8'h00;
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stage_en", stage_en, 0);
        chk("rst_count", tile_count, 0);
        in_valid = 1'b0;
        step(); reset = 1'b1;

        // single beat walking the empty pipe
        step(); in_valid = 1'b1; in_data = 8'h10; #1;
        chk("t1_in_ready", in_ready, 1);
        chk("t1_en0", stage_en, 4'b0001);
        step(); in_valid = 1'b0; #1;
        chk("t1_en1", stage_en, 4'b0010);
        step(); chk("t1_en2", stage_en, 4'b0100);
        step(); chk("t1_en3", stage_en, 4'b1000);
        chk("t1_out_early", out_valid, 0);
        step(); chk("t1_out_valid", out_valid, 1);
        chk("t1_occ_out", occupancy, 1);
        step(); chk("t1_occ_empty", occupancy, 0);
        chk("t1_out_gone", out_valid, 0);

        // 8 back-to-back beats, last on beat 8
        seen = 0; rises = 0; dones = 0; prev = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            in_valid = (k < 8);
            in_data  = 8'h20 + 8'(k);
            in_last  = (k == 7);
            #1;
            if (k < 8) chk("t2_in_ready", in_ready, 1);
            if (out_valid) seen++;
            if (out_valid && !prev) rises++;
            if (tile_done) dones++;
            prev = out_valid;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("t2_valid_cycles", seen, 8);
        chk("t2_valid_runs", rises, 1);
        chk("t2_done_pulses", dones, 1);
        chk("t2_count", tile_count, 1);

        // fill under backpressure, hold, then release
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h40 + 8'(n);
            #1;
            if (!in_ready) break;
            n++;
        end
        chk("t3_accepted", n, 4);
        chk("t3_occ_full", occupancy, 4);
        chk("t3_in_ready", in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_hold_en", stage_en, 0);
            chk("t3_hold_occ", occupancy, 4);
        end
        seen = 0; rises = 0; prev = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            out_ready = 1'b1; in_valid = (k < 4); in_data = 8'h44 + 8'(k);
            #1;
            if (k < 4) chk("t3_resume_ready", in_ready, 1);
            if (k < 4) chk("t3_full_occ", occupancy, 4);
            if (out_valid) seen++;
            if (out_valid && !prev) rises++;
            prev = out_valid;
        end
        chk("t3_out_beats", seen, 8);
        chk("t3_out_runs", rises, 1);
        chk("t3_sb_empty", q.size(), 0);

        // bubble collapse: beats in stages 3 and 0, then a new beat
        step(); out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b1; in_data = 8'h60;
        step(); in_valid = 1'b0; in_last = 1'b0;
        step(); step();
        step(); in_valid = 1'b1; in_data = 8'h61; #1;
        chk("t4_en_first", stage_en, 4'b0001);
        step(); in_data = 8'h62; #1;
        chk("t4_en_collapse", stage_en, 4'b0011);

        // flush with occupancy 3 and a last-tagged beat at the output
        step(); in_valid = 1'b0; #1;
        chk("t5_pre_occ", occupancy, 3);
        chk("t5_pre_last", out_last, 1);
        flush = 1'b1; out_ready = 1'b1; #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_stage_en", stage_en, 0);
        step(); flush = 1'b0; #1;
        chk("t5_occ_cleared", occupancy, 0);
        step(); chk("t5_count_kept", tile_count, 1);

        // counter wrap on the 2-bit instance, after a fresh reset
        step(); reset = 1'b0; #1;
        chk("t6_async_count", tile_count, 0);
        step(); reset = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step(); in_valid = 1'b1; in_last = 1'b1; in_data = 8'h80 + 8'(t);
            step(); in_valid = 1'b0; in_last = 1'b0;
            repeat (S + 2) step();
            chk("t6_count_w2", tile_count_b, (t + 1) % 4);
        end

        // reset mid-stream discards in-flight beats without a clock edge
        for (int k = 0; k < 6; k++) begin
            step(); in_valid = 1'b1; in_data = 8'h90 + 8'(k);
        end
        #1;
        chk("t6_pre_valid", out_valid, 1);
        #1; reset = 1'b0; #1;
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_occ", occupancy, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_count_w2", tile_count_b, 0);
        step(); in_valid = 1'b0;
        step(); reset = 1'b1;
        repeat (3) step();
        chk("t6_no_done", tile_done, 0);
        chk("t6_occ_after", occupancy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
